nn_cfg_loader: RTL and testbench

Configuration-stream sequencer that drives the broadcast weight/bias load bus shared by all neuron instances. It accepts a 32-bit packetised word stream (header + payload) over a valid/ready handshake and emits one-cycle `weightValid`/`biasValid` strobes with the target layer/neuron numbers held stable on `config_layer_num`/`config_neuron_num`. It is the transmitter for the neurons' weight-memory and bias receive ports and sits between the host configuration FIFO and the layer array.

---
 rtl/nn_cfg_if.sv | 29 ++
 rtl/nn_cfg_loader.sv | 130 +++++++++++++
 tb/tb_nn_cfg_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_cfg_if.sv
// Configuration stream and broadcast weight/bias load bus of nn_cfg_loader.
// A word transfers on a cycle with cfg_valid & cfg_ready; cfg_ready never depends on cfg_valid.
interface nn_cfg_if;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        err_clr;
  logic        weightValid;
  logic        biasValid;
  logic [31:0] weightValue;
  logic [31:0] biasValue;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic        busy;
  logic        pkt_done;
  logic        err;

  modport master (
    output cfg_data, cfg_valid, err_clr,
    input  cfg_ready, weightValid, biasValid, weightValue, biasValue,
    input  config_layer_num, config_neuron_num, busy, pkt_done, err
  );

  modport slave (
    input  cfg_data, cfg_valid, err_clr,
    output cfg_ready, weightValid, biasValid, weightValue, biasValue,
    output config_layer_num, config_neuron_num, busy, pkt_done, err
  );
endinterface

// File: rtl/nn_cfg_loader.sv
// Packetised config-stream sequencer: decodes header+payload and strobes
// weights/biases onto the broadcast neuron load bus.
module nn_cfg_loader #(
  parameter int maxCount = 784
) (
  input  logic       clk,
  input  logic       rst,
  nn_cfg_if.slave    bus,
  output logic [1:0] dbg_state_o
);
  localparam int          CW      = $clog2(maxCount + 1);
  localparam logic [15:0] MAX_CNT = 16'(maxCount);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  rem_q, rem_d;
  logic           is_bias_q, is_bias_d;
  logic [5:0]     layer_q, layer_d;
  logic [7:0]     neuron_q, neuron_d;
  logic [31:0]    wval_q, wval_d;
  logic [31:0]    bval_q, bval_d;
  logic           wv_q, wv_d;
  logic           bv_q, bv_d;
  logic           done_q, done_d;

  logic           beat;
  logic [1:0]     hdr_type;
  logic [15:0]    hdr_cnt;
  logic           hdr_legal;

  assign hdr_type = bus.cfg_data[31:30];
  assign hdr_cnt  = bus.cfg_data[15:0];
  assign beat     = bus.cfg_valid & bus.cfg_ready;

  // Bias packets carry exactly one word; weight packets 1..maxCount.
  assign hdr_legal = ((hdr_type == 2'b01) || (hdr_type == 2'b10)) &&
                     (hdr_cnt != 16'd0) && (hdr_cnt <= MAX_CNT) &&
                     !((hdr_type == 2'b10) && (hdr_cnt != 16'd1));

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    is_bias_d = is_bias_q;
    layer_d   = layer_q;
    neuron_d  = neuron_q;
    wval_d    = wval_q;
    bval_d    = bval_q;
    wv_d      = 1'b0;
    bv_d      = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (beat) begin
          if (hdr_legal) begin
            state_d   = S_DATA;
            is_bias_d = (hdr_type == 2'b10);
            layer_d   = bus.cfg_data[29:24];
            neuron_d  = bus.cfg_data[23:16];
            rem_d     = hdr_cnt[CW-1:0];
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DATA: begin
        if (beat) begin
          if (is_bias_q) begin
            bval_d = bus.cfg_data;
            bv_d   = 1'b1;
          end else begin
            wval_d = bus.cfg_data;
            wv_d   = 1'b1;
          end
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_ERR: begin
        if (bus.err_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      is_bias_q <= 1'b0;
      layer_q   <= '0;
      neuron_q  <= '0;
      wval_q    <= '0;
      bval_q    <= '0;
      wv_q      <= 1'b0;
      bv_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      is_bias_q <= is_bias_d;
      layer_q   <= layer_d;
      neuron_q  <= neuron_d;
      wval_q    <= wval_d;
      bval_q    <= bval_d;
      wv_q      <= wv_d;
      bv_q      <= bv_d;
      done_q    <= done_d;
    end
  end

  assign bus.cfg_ready         = (state_q != S_ERR);
  assign bus.busy              = (state_q == S_DATA);
  assign bus.err               = (state_q == S_ERR);
  assign bus.weightValid       = wv_q;
  assign bus.biasValid         = bv_q;
  assign bus.weightValue       = wval_q;
  assign bus.biasValue         = bval_q;
  assign bus.pkt_done          = done_q;
  assign bus.config_layer_num  = {26'd0, layer_q};
  assign bus.config_neuron_num = {24'd0, neuron_q};
  assign dbg_state_o           = state_q;
endmodule

// File: tb/tb_nn_cfg_loader.sv
// Bench for nn_cfg_loader: directed test-plan sequences with literal checks,
// then randomized packet traffic checked each cycle against a stream model.
module tb_nn_cfg_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;
  nn_cfg_if   bus();

  nn_cfg_loader #(.maxCount(784)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;
  logic [31:0] exp_q[$];

  // Stream model: words left in the current packet (0 = between packets).
  int          m_left   = 0;
  bit          m_err    = 1'b0;
  bit          m_bias   = 1'b0;
  bit          m_wv     = 1'b0;
  bit          m_bv     = 1'b0;
  bit          m_done   = 1'b0;
  logic [31:0] m_layer  = '0;
  logic [31:0] m_neuron = '0;
  logic [31:0] m_wval   = '0;
  logic [31:0] m_bval   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_hdr(input logic [31:0] h);
    int t;
    int c;
    t = int'(h[31:30]);
    c = int'(h[15:0]);
    if (t != 1 && t != 2) return 1'b0;
    if (c == 0 || c > 784) return 1'b0;
    if (t == 2 && c != 1) return 1'b0;
    return 1'b1;
  endfunction

  // Advances the model by one clock using the inputs about to be sampled.
  task automatic model_cycle();
    m_wv = 1'b0; m_bv = 1'b0; m_done = 1'b0;
    if (!rst) begin
      m_left = 0; m_err = 1'b0; m_bias = 1'b0;
      m_layer = '0; m_neuron = '0; m_wval = '0; m_bval = '0;
      exp_q.delete();
    end else if (m_err) begin
      if (bus.err_clr) m_err = 1'b0;
    end else if (bus.cfg_valid) begin
      if (m_left == 0) begin
        if (legal_hdr(bus.cfg_data)) begin
          m_bias   = (bus.cfg_data[31:30] == 2'b10);
          m_layer  = 32'(bus.cfg_data[29:24]);
          m_neuron = 32'(bus.cfg_data[23:16]);
          m_left   = int'(bus.cfg_data[15:0]);
        end else begin
          m_err = 1'b1;
        end
      end else begin
        if (m_bias) begin m_bv = 1'b1; m_bval = bus.cfg_data; end
        else        begin m_wv = 1'b1; m_wval = bus.cfg_data; end
        exp_q.push_back(bus.cfg_data);
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit clr = 1'b0, input bit r = 1'b1);
    @(negedge clk);
    rst           = r;
    bus.cfg_valid = v;
    bus.cfg_data  = d;
    bus.err_clr   = clr;
    model_cycle();
    cmp_en = 1'b1;
  endtask

  task automatic post();
    @(posedge clk);
    #3;
  endtask

  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      chk("cfg_ready", 32'(bus.cfg_ready),   32'(!m_err));
      chk("busy",      32'(bus.busy),        32'(m_left != 0));
      chk("err",       32'(bus.err),         32'(m_err));
      chk("wvalid",    32'(bus.weightValid), 32'(m_wv));
      chk("bvalid",    32'(bus.biasValid),   32'(m_bv));
      chk("pkt_done",  32'(bus.pkt_done),    32'(m_done));
      chk("wvalue",    bus.weightValue,       m_wval);
      chk("bvalue",    bus.biasValue,         m_bval);
      chk("layer",     bus.config_layer_num,  m_layer);
      chk("neuron",    bus.config_neuron_num, m_neuron);
      if (bus.weightValid || bus.biasValid) begin
        if (exp_q.size() == 0) chk("sb_unexpected_strobe", 32'd1, 32'd0);
        else if (bus.weightValid) chk("sb_word", bus.weightValue, exp_q.pop_front());
        else                      chk("sb_word", bus.biasValue,   exp_q.pop_front());
      end
    end
  end

  function automatic bit rnd_clr();
    return ($urandom_range(0, 9) == 0);
  endfunction

  task automatic send_word(input logic [31:0] d, input bit bubbles);
    if (bubbles) repeat ($urandom_range(0, 2)) drive(1'b0, $urandom, rnd_clr());
    drive(1'b1, d, rnd_clr());
  endtask

  task automatic send_pkt(input logic [31:0] hdr, input int words);
    send_word(hdr, 1'b1);
    for (int i = 0; i < words; i++) send_word($urandom, 1'b1);
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.err_clr   = 1'b0;

    repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rst_ready",  32'(bus.cfg_ready), 32'd1);
    chk("rst_busy",   32'(bus.busy),      32'd0);
    chk("rst_err",    32'(bus.err),       32'd0);
    chk("rst_wvalue", bus.weightValue,    32'd0);
    chk("rst_layer",  bus.config_layer_num, 32'd0);
    drive(1'b0, 32'h0);

    // Weight packet, layer 1 neuron 3, three words.
    drive(1'b1, 32'h4103_0003); post();
    chk("w_hdr_busy",   32'(bus.busy), 32'd1);
    chk("w_hdr_layer",  bus.config_layer_num,  32'd1);
    chk("w_hdr_neuron", bus.config_neuron_num, 32'd3);
    drive(1'b1, 32'h0000_00AA); post();
    chk("w_aa_valid", 32'(bus.weightValid), 32'd1);
    chk("w_aa_value", bus.weightValue, 32'h0000_00AA);
    drive(1'b1, 32'h0000_00BB); post();
    chk("w_bb_value", bus.weightValue, 32'h0000_00BB);
    drive(1'b1, 32'h0000_00CC); post();
    chk("w_cc_value", bus.weightValue, 32'h0000_00CC);
    chk("w_cc_done",  32'(bus.pkt_done), 32'd1);
    chk("w_cc_busy",  32'(bus.busy), 32'd0);
    drive(1'b0, 32'h0); post();
    chk("w_after_valid", 32'(bus.weightValid), 32'd0);

    // Bias packet, layer 2 neuron 7.
    drive(1'b1, 32'h8207_0001);
    drive(1'b1, 32'h0000_05FB); post();
    chk("b_valid",  32'(bus.biasValid), 32'd1);
    chk("b_value",  bus.biasValue, 32'h0000_05FB);
    chk("b_layer",  bus.config_layer_num, 32'd2);
    chk("b_neuron", bus.config_neuron_num, 32'd7);
    chk("b_wvalid", 32'(bus.weightValid), 32'd0);

    // Bubbles between words 1 and 2.
    drive(1'b1, 32'h4103_0003);
    drive(1'b1, 32'h0000_0011);
    drive(1'b0, 32'h0000_0022); post();
    chk("bub_valid", 32'(bus.weightValid), 32'd0);
    chk("bub_busy",  32'(bus.busy), 32'd1);
    drive(1'b0, 32'h0000_0022);
    drive(1'b1, 32'h0000_0022);
    drive(1'b1, 32'h0000_0033); post();
    chk("bub_last", bus.weightValue, 32'h0000_0033);

    // Illegal headers and err_clr.
    drive(1'b1, 32'hC100_0002); post();
    chk("e_type_err",   32'(bus.err), 32'd1);
    chk("e_type_ready", 32'(bus.cfg_ready), 32'd0);
    drive(1'b1, 32'h4103_0001);
    drive(1'b1, 32'h0000_0055); post();
    chk("e_ignored", 32'(bus.weightValid), 32'd0);
    drive(1'b0, 32'h0, 1'b1); post();
    chk("e_clr_ready", 32'(bus.cfg_ready), 32'd1);
    drive(1'b1, 32'h4100_0000); post();
    chk("e_cnt0", 32'(bus.err), 32'd1);
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b1, 32'h8100_0002); post();
    chk("e_bias2", 32'(bus.err), 32'd1);
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b1, 32'h4100_0311); post();
    chk("e_785", 32'(bus.err), 32'd1);
    drive(1'b0, 32'h0, 1'b1);

    // Back-to-back packets for neurons 0 and 1.
    drive(1'b1, 32'h4100_0002);
    drive(1'b1, 32'h0000_0001);
    drive(1'b1, 32'h0000_0002); post();
    chk("bb_s2_neuron", bus.config_neuron_num, 32'd0);
    drive(1'b1, 32'h4101_0002);
    drive(1'b1, 32'h0000_0003); post();
    chk("bb_s3_neuron", bus.config_neuron_num, 32'd1);
    chk("bb_s3_value",  bus.weightValue, 32'h0000_0003);
    drive(1'b1, 32'h0000_0004);

    // Reset in the middle of a packet.
    drive(1'b1, 32'h4103_0003);
    drive(1'b1, 32'h0000_0077);
    drive(1'b1, 32'h0000_0088, 1'b0, 1'b0);
    #1;
    chk("mr_wvalid", 32'(bus.weightValid), 32'd0);
    chk("mr_wvalue", bus.weightValue, 32'd0);
    chk("mr_busy",   32'(bus.busy), 32'd0);
    chk("mr_layer",  bus.config_layer_num, 32'd0);
    drive(1'b1, 32'h0000_0099, 1'b0, 1'b0);
    drive(1'b1, 32'h4105_0001); post();
    chk("mr_new_busy",   32'(bus.busy), 32'd1);
    chk("mr_new_neuron", bus.config_neuron_num, 32'd5);
    drive(1'b1, 32'h0000_1234);

    // Longest legal packet.
    drive(1'b1, {2'b01, 6'd9, 8'd200, 16'd784});
    for (int i = 0; i < 784; i++) drive(1'b1, $urandom);
    drive(1'b0, 32'h0);

    // Randomized traffic.
    for (int p = 0; p < 250; p++) begin
      int k;
      int c;
      k = $urandom_range(0, 9);
      if (k < 6) begin
        c = $urandom_range(1, 6);
        send_pkt({2'b01, 6'($urandom), 8'($urandom), 16'(c)}, c);
      end else if (k < 8) begin
        send_pkt({2'b10, 6'($urandom), 8'($urandom), 16'd1}, 1);
      end else begin
        case ($urandom_range(0, 3))
          0:       c = 32'({2'b00, 14'($urandom), 16'($urandom_range(1, 9))});
          1:       c = 32'({2'b11, 14'($urandom), 16'($urandom_range(1, 9))});
          2:       c = 32'({2'b01, 14'($urandom), 16'($urandom_range(785, 65535))});
          default: c = 32'({2'b10, 14'($urandom), 16'($urandom_range(2, 40))});
        endcase
        drive(1'b1, 32'(c));
        repeat ($urandom_range(0, 3)) drive(1'b1, $urandom);
        drive($urandom_range(0, 1) == 1, $urandom, 1'b1);
      end
      if ($urandom_range(0, 39) == 0) begin
        drive(1'b1, $urandom, 1'b0, 1'b0);
        drive(1'b0, 32'h0);
      end
    end

    drive(1'b0, 32'h0);
    drive(1'b0, 32'h0);
    post();
    chk("sb_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
